// File: rtl/mem_stage_if.sv
// Bundle of the execute-side, write-back-side and data-memory signals of the memory stage.
// The master modport is the stage itself; the slave modport is its surrounding pipeline and memory.
interface mem_stage_if;
  logic [73:0] exebus;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [73:0] membus;
  logic        mem_err;

  modport master (
    input  exebus, dmem_ack, dmem_rdata,
    output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, membus, mem_err
  );

  modport slave (
    output exebus, dmem_ack, dmem_rdata,
    input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, membus, mem_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus into membus, runs loads/stores
// over a req/ack data-memory handshake, stalls upstream meanwhile and times out hung accesses.
module mem_stage #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.master mif
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state, w_next_state;
  logic [7:0]  r_wd;
  logic [3:0]  r_hold_op;
  logic [4:0]  r_hold_dst;
  logic [31:0] r_hold_res;
  logic        r_req, r_we, r_err;
  logic [31:0] r_addr, r_wdata;
  logic [73:0] r_membus;
  logic        w_mem_stall;

  logic        w_valid;
  logic [3:0]  w_op;
  logic [4:0]  w_dst;
  logic [31:0] w_res, w_sdata;
  logic        w_mem_op, w_ack, w_wd_expired, w_hold_load;

  assign w_valid      = mif.exebus[73];
  assign w_op         = mif.exebus[72:69];
  assign w_dst        = mif.exebus[68:64];
  assign w_res        = mif.exebus[63:32];
  assign w_sdata      = mif.exebus[31:0];
  assign w_mem_op     = w_valid & ((w_op == OP_LOAD) | (w_op == OP_STORE));
  // An ack only counts while a request is actually outstanding.
  assign w_ack        = mif.dmem_ack & r_req;
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_hold_load  = (r_hold_op == OP_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: each always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_mem_op) w_next_state = WAIT;
      WAIT: if (w_ack || w_wd_expired) w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_mem_stall = 1'b0;
    case (r_state)
      IDLE: w_mem_stall = w_mem_op;
      WAIT: w_mem_stall = !(w_ack || w_wd_expired);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd       <= '0;
      r_hold_op  <= '0;
      r_hold_dst <= '0;
      r_hold_res <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_membus   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_hold_op  <= w_op;
            r_hold_dst <= w_dst;
            r_hold_res <= w_res;
            r_req      <= 1'b1;
            r_we       <= (w_op == OP_STORE);
            r_addr     <= {w_res[31:2], 2'b00};
            r_wdata    <= w_sdata;
            r_wd       <= '0;
            r_membus   <= '0;
          end else if (w_valid) begin
            r_membus <= {1'b1, w_op, w_dst, w_res, 32'h0};
          end else begin
            r_membus <= '0;
          end
        end
        WAIT: begin
          if (w_ack) begin
            r_req    <= 1'b0;
            r_membus <= {1'b1, r_hold_op, r_hold_dst, r_hold_res,
                         w_hold_load ? mif.dmem_rdata : 32'h0};
          end else if (w_wd_expired) begin
            r_req    <= 1'b0;
            r_err    <= 1'b1;
            r_membus <= {1'b1, r_hold_op, r_hold_dst, r_hold_res,
                         w_hold_load ? ERR_DATA : 32'h0};
          end else begin
            r_wd     <= r_wd + 8'd1;
            r_membus <= '0;
          end
        end
      endcase
    end
  end

  assign mif.mem_stall  = w_mem_stall;
  assign mif.dmem_req   = r_req;
  assign mif.dmem_we    = r_we;
  assign mif.dmem_addr  = r_addr;
  assign mif.dmem_wdata = r_wdata;
  assign mif.membus     = r_membus;
  assign mif.mem_err    = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage: each exebus transaction is scored against
// the expected stall window, request fields, membus result and timeout behaviour.
module tb_mem_stage;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
  localparam logic [3:0]  OP_LOAD  = 4'b1000;
  localparam logic [3:0]  OP_STORE = 4'b1001;
  localparam int          NEVER    = 1000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_stage_if u_if ();

  mem_stage #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [73:0] got, input logic [73:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One whole transaction, driven and checked from a negedge to a negedge.
  // ack_delay = number of WAIT cycles without ack before the ack cycle (NEVER = no ack).
  task automatic run_op(input logic valid, input logic [3:0] op, input logic [4:0] dst,
                        input logic [31:0] res, input logic [31:0] sdata,
                        input int ack_delay, input bit scramble, input bit stray_ack);
    logic        is_mem;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    int          req_cycles;
    bit          done;
    is_mem     = valid && (op == OP_LOAD || op == OP_STORE);
    rdata      = $urandom;
    exp_addr   = {res[31:2], 2'b00};
    req_cycles = 0;
    done       = 1'b0;
    u_if.exebus   = {valid, op, dst, res, sdata};
    u_if.dmem_ack = 1'b0;
    if (!is_mem) begin
      if (stray_ack) begin
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = $urandom;
      end
      #1 check("stall_nonmem", 74'(u_if.mem_stall), 74'(0));
      @(negedge clk);
      u_if.dmem_ack = 1'b0;
      check("membus_nonmem", u_if.membus, valid ? {1'b1, op, dst, res, 32'h0} : 74'h0);
      check("req_err_nonmem", 74'({u_if.dmem_req, u_if.mem_err}), 74'(0));
    end else begin
      #1 check("stall_present", 74'(u_if.mem_stall), 74'(1));
      @(negedge clk);
      check("issue_req_we", 74'({u_if.dmem_req, u_if.dmem_we}), 74'({1'b1, op == OP_STORE}));
      check("issue_addr", 74'(u_if.dmem_addr), 74'(exp_addr));
      check("issue_wdata", 74'(u_if.dmem_wdata), 74'(sdata));
      check("issue_bubble", 74'({u_if.membus[73], u_if.mem_err}), 74'(0));
      for (int k = 0; k < TIMEOUT && !done; k++) begin
        if (u_if.dmem_req) req_cycles++;
        if (scramble) u_if.exebus = 74'({$urandom(), $urandom(), $urandom()});
        if (k == ack_delay) begin
          u_if.dmem_ack   = 1'b1;
          u_if.dmem_rdata = rdata;
          #1 check("stall_ack", 74'(u_if.mem_stall), 74'(0));
          @(negedge clk);
          u_if.dmem_ack = 1'b0;
          check("membus_done", u_if.membus,
                {1'b1, op, dst, res, (op == OP_LOAD) ? rdata : 32'h0});
          check("req_err_done", 74'({u_if.dmem_req, u_if.mem_err}), 74'(0));
          done = 1'b1;
        end else if (k == TIMEOUT - 1) begin
          #1 check("stall_timeout", 74'(u_if.mem_stall), 74'(0));
          @(negedge clk);
          check("membus_timeout", u_if.membus,
                {1'b1, op, dst, res, (op == OP_LOAD) ? ERR_DATA : 32'h0});
          check("req_err_timeout", 74'({u_if.dmem_req, u_if.mem_err}), 74'(2'b01));
          done = 1'b1;
        end else begin
          #1 check("stall_wait", 74'(u_if.mem_stall), 74'(1));
          check("held_req", 74'({u_if.dmem_we, u_if.dmem_addr, u_if.dmem_wdata}),
                74'({op == OP_STORE, exp_addr, sdata}));
          @(negedge clk);
          check("wait_bubble", 74'({u_if.membus[73], u_if.mem_err}), 74'(0));
        end
      end
      check("req_cycles", 74'(req_cycles),
            74'((ack_delay < TIMEOUT) ? ack_delay + 1 : TIMEOUT));
    end
  endtask

  initial begin
    logic [73:0] eb;
    logic        exp_stall;
    int          cls, r, dly;
    logic [3:0]  op;

    reset           = 1'b0;
    u_if.exebus     = '0;
    u_if.dmem_ack   = 1'b0;
    u_if.dmem_rdata = '0;

    // Reset held low with live exebus: outputs cleared, stall purely combinational.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      eb = (i == 0) ? {1'b1, OP_LOAD, 5'd1, 32'h40, 32'h0}
                    : 74'({$urandom(), $urandom(), $urandom()});
      u_if.exebus = eb;
      exp_stall = eb[73] && (eb[72:69] == OP_LOAD || eb[72:69] == OP_STORE);
      #1;
      check("rst_membus", u_if.membus, 74'h0);
      check("rst_req_err", 74'({u_if.dmem_req, u_if.mem_err}), 74'(0));
      check("rst_stall", 74'(u_if.mem_stall), 74'(exp_stall));
    end
    @(negedge clk);
    u_if.exebus = '0;
    reset = 1'b1;

    // Directed scenarios.
    @(negedge clk);
    run_op(1'b1, 4'b0010, 5'd7, 32'h12345678, 32'h0, 0, 1'b0, 1'b0);
    run_op(1'b1, OP_LOAD, 5'd3, 32'h00001003, 32'h0, 2, 1'b0, 1'b0);
    run_op(1'b1, OP_STORE, 5'd9, 32'h00000020, 32'hA5A5A5A5, 1, 1'b0, 1'b0);
    run_op(1'b1, OP_LOAD, 5'd4, 32'h00000104, 32'h0, 0, 1'b0, 1'b0);
    run_op(1'b1, OP_STORE, 5'd5, 32'h00000108, 32'h11223344, 0, 1'b0, 1'b0);
    run_op(1'b1, OP_LOAD, 5'd6, 32'h00000200, 32'h0, NEVER, 1'b0, 1'b0);
    run_op(1'b0, 4'b0000, 5'd0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    run_op(1'b1, OP_LOAD, 5'd8, 32'h00000300, 32'h0, TIMEOUT - 1, 1'b0, 1'b0);
    run_op(1'b1, OP_STORE, 5'd2, 32'h00000400, 32'h0BADF00D, NEVER, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 5);
      r   = $urandom_range(0, 9);
      dly = (r < 7) ? r % 4 : (r == 7) ? TIMEOUT - 1 : (r == 8) ? NEVER
                    : $urandom_range(0, TIMEOUT - 2);
      case (cls)
        0:       op = {1'b0, 3'($urandom)};
        1:       op = {1'b1, 3'($urandom_range(2, 7))};
        3:       op = OP_LOAD;
        4:       op = OP_STORE;
        default: op = 4'($urandom);
      endcase
      run_op(cls != 2, op, 5'($urandom), $urandom, $urandom, dly,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    // Reset asserted two cycles after a load issue, between clock edges.
    u_if.exebus = {1'b1, OP_LOAD, 5'd3, 32'h00000500, 32'h0};
    @(negedge clk);
    u_if.exebus = '0;
    check("mid_issue_req", 74'(u_if.dmem_req), 74'(1));
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_req", 74'(u_if.dmem_req), 74'(0));
    check("mid_rst_membus", u_if.membus, 74'h0);
    @(negedge clk);
    u_if.dmem_ack   = 1'b1;
    u_if.dmem_rdata = 32'h55555555;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet",
            74'({u_if.membus[73], u_if.mem_err, u_if.dmem_req, u_if.mem_stall}), 74'(0));
    end
    u_if.dmem_ack = 1'b0;
    run_op(1'b1, OP_LOAD, 5'd1, 32'h00000604, 32'h0, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage sitting between the execute stage and the write-back stage. It registers the execute result bus into the 74-bit membus consumed by write-back. Loads and stores go through a variable-latency req/ack data-memory handshake. While an access is outstanding the stage stalls upstream and emits bubbles downstream. A watchdog converts a hung access into an error result.

Parameters:
TIMEOUT, 16, max cycles dmem_req may stay high without dmem_ack before the access is abandoned (legal range 2..255).
ERR_DATA, 32'hDEADBEEF, memres value returned for a timed-out load.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
exebus  input  74  {valid[73], op[72:69], dst[68:64], res[63:32] (ALU result / address), sdata[31:0] (store data)}.
mem_stall  output  1  combinational; upstream must hold exebus unchanged while high.
dmem_req  output  1  registered memory request, held until ack or timeout.
dmem_we  output  1  registered; 1 = store, 0 = load.
dmem_addr  output  32  registered; {res[31:2], 2'b00}.
dmem_wdata  output  32  registered store data.
dmem_ack  input  1  one-cycle completion strobe; valid only while dmem_req = 1.
dmem_rdata  input  32  load data, sampled in the ack cycle.
membus  output  74  registered: {valid[73], op[72:69], dst[68:64], res[63:32], memres[31:0]}.
mem_err  output  1  registered one-cycle pulse on timeout.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; membus, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err, watchdog counter all cleared. An outstanding request is dropped immediately. Any late ack after reset is ignored.
- Op classes (exebus op): op[3] = 0 is ALU; 4'b1000 is LOAD; 4'b1001 is STORE; any other op[3] = 1 code is non-mem. Memory op = valid & (LOAD | STORE).
- FSM states: IDLE, WAIT.
- IDLE with a valid non-memory op:
  - The next edge registers membus = {1, op, dst, res, 32'h0}.
  - Latency is 1 cycle and mem_stall = 0.
- IDLE with exebus invalid: the next edge registers membus = 0 (bubble).
- IDLE with a memory op:
  - mem_stall = 1.
  - The next edge latches op, dst, res into holding registers and drives dmem_req = 1, dmem_we = (op == STORE), dmem_addr, dmem_wdata.
  - Watchdog clears; state moves to WAIT; membus valid = 0 for that edge.
- WAIT, no ack:
  - mem_stall = 1; the watchdog increments; membus valid = 0 each cycle.
  - Request outputs are held stable.
- WAIT with dmem_ack = 1:
  - mem_stall = 0 in that cycle, so upstream advances at that edge.
  - At the edge: membus = {1, held op, held dst, held res, LOAD ? dmem_rdata : 32'h0}, dmem_req = 0, state = IDLE.
  - Minimum load latency is 2 cycles from exebus presentation (issue edge plus ack in the next cycle).
- WAIT with the watchdog reaching TIMEOUT-1 and no ack:
  - mem_stall = 0 in that cycle.
  - At the edge: dmem_req = 0, mem_err pulses 1 for one cycle, state = IDLE.
  - membus = {1, op, dst, res, LOAD ? ERR_DATA : 32'h0}.
- Ack on the timeout cycle: the ack wins; normal completion and no mem_err.
- dmem_ack while dmem_req = 0 is ignored.
- Misaligned addresses: res[1:0] is discarded (word access only). No error is raised.
- Back-to-back memory ops: the second op is presented in the cycle after the first's ack edge. Since IDLE is re-entered there, it issues on the following edge, with no extra bubble beyond the issue cycle.
- Held request registers do not change while in WAIT, even if exebus changes (a protocol violation upstream).

Test Plan:
- Reset: hold reset = 0 with a random exebus for 3 cycles -> membus = 0, dmem_req = 0, mem_stall reflects only the combinational input. Releasing reset -> IDLE.
- ALU pass-through: exebus = {1, 4'b0010, 5'd7, 32'h12345678, x} -> next cycle membus = {1, 0010, 7, 12345678, 0}, mem_stall = 0, dmem_req never asserted.
- Load, 3-cycle ack delay: LOAD dst = 3, res = 32'h1003 -> dmem_addr = 32'h1000, dmem_we = 0. With dmem_rdata = 32'hCAFEF00D on ack -> membus = {1, 1000, 3, 1003, CAFEF00D} exactly one cycle. mem_stall is high from presentation until the ack cycle; bubbles appear before that.
- Store: STORE res = 32'h20, sdata = 32'hA5A5A5A5, ack after 1 cycle -> dmem_we = 1, dmem_wdata = A5A5A5A5, then membus = {1, 1001, dst, 20, 0}.
- Timeout: LOAD with no ack -> dmem_req high exactly TIMEOUT cycles, then mem_err pulses once and membus memres = DEADBEEF. A late ack afterwards is ignored.
- Reset mid-WAIT: assert reset two cycles after a load issue -> dmem_req drops asynchronously, state = IDLE, no membus valid or mem_err after release.
